// File: rtl/bcd_entry_reader.sv
// Debounced 3-digit BCD switch entry, converted to an 8-bit binary value
// and offered to the CPU bus as a readable port with a valid/read handshake.
module bcd_entry_reader #(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic       start,
  input  logic       rd,
  output logic [7:0] value_out,
  output logic       valid,
  output logic       busy,
  output logic       ovf,
  output logic       err
);

  localparam int CW = $clog2(DB_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  logic          s1_q, s2_q;
  logic          db_q, dbp_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  state_e        state_q;
  logic [1:0]    idx_q;
  logic [11:0]   acc_q;
  logic [3:0]    d0_q, d1_q, d2_q;
  logic          eacc_q;
  logic [7:0]    value_q;
  logic          valid_q, ovf_q, err_q;

  logic [3:0]    dsel_d;
  logic [11:0]   acc_d;
  logic          eacc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      dbp_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= start;
      s2_q    <= s1_q;
      dbp_q   <= db_q;
      press_q <= db_q & ~dbp_q;
      if (s2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (idx_q)
      2'd2:    dsel_d = d2_q;
      2'd1:    dsel_d = d1_q;
      default: dsel_d = d0_q;
    endcase
    // acc*10 as (acc<<3)+(acc<<1); 12 bits hold the 15/15/15 worst case
    acc_d  = {acc_q[8:0], 3'b000}
           + {acc_q[10:0], 1'b0}
           + {8'd0, dsel_d};
    eacc_d = eacc_q | (dsel_d > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      acc_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      eacc_q  <= 1'b0;
      value_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (press_q) begin
            d0_q    <= digit0;
            d1_q    <= digit1;
            d2_q    <= digit2;
            acc_q   <= '0;
            idx_q   <= 2'd2;
            eacc_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            state_q <= CONV;
          end else if (state_q == DONE && rd) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        CONV: begin
          acc_q  <= acc_d;
          eacc_q <= eacc_d;
          idx_q  <= idx_q - 2'd1;
          if (idx_q == 2'd0) begin
            if (eacc_d) begin
              value_q <= 8'd0;
              err_q   <= 1'b1;
              ovf_q   <= 1'b0;
            end else if (acc_d > 12'd255) begin
              value_q <= 8'hFF;
              ovf_q   <= 1'b1;
            end else begin
              value_q <= acc_d[7:0];
            end
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign value_out = value_q;
  assign valid     = valid_q;
  assign busy      = (state_q == CONV);
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_entry_reader.sv
// Scoreboard bench for bcd_entry_reader: expected results are queued at
// each press and matched against results captured on every valid rise.
module tb_bcd_entry_reader;

  typedef struct packed {
    logic [7:0] v;
    logic       o;
    logic       e;
    logic [7:0] b;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit0, digit1, digit2;
  logic       start, rd;
  logic [7:0] value_out;
  logic       valid, busy, ovf, err;

  int   total  = 0;
  int   passed = 0;
  int   kpress = 8;
  res_t exp_q[$];
  res_t obs_q[$];
  logic [7:0] bcnt = 8'd0;
  logic       pv   = 1'b0;

  bcd_entry_reader #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .start(start), .rd(rd),
    .value_out(value_out), .valid(valid), .busy(busy),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt = 8'd0;
      pv   = 1'b0;
    end else begin
      if (busy) bcnt = bcnt + 8'd1;
      if (valid && !pv) begin
        obs_q.push_back({value_out, ovf, err, bcnt});
        bcnt = 8'd0;
      end
      pv = valid;
    end
  end

  function automatic res_t model(input int h, input int t, input int u);
    res_t r;
    int   f;
    r.b = 8'd3;
    if (h > 9 || t > 9 || u > 9) begin
      r.v = 8'd0; r.o = 1'b0; r.e = 1'b1;
    end else begin
      f = h * 100 + t * 10 + u;
      r.e = 1'b0;
      if (f > 255) begin
        r.v = 8'd255; r.o = 1'b1;
      end else begin
        r.v = 8'(f); r.o = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic set_digits(input int h, input int t, input int u);
    digit2 = 4'(h);
    digit1 = 4'(t);
    digit0 = 4'(u);
  endtask

  task automatic tap();
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = (obs_q.size() >= exp_q.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rd = 1'b0;
    set_digits(0, 0, 0);
    repeat (2) @(negedge clk);
    total++;
    if ({value_out, valid, busy, ovf, err} !== 12'd0)
      $display("FAIL reset_outputs got %h want 000",
               {value_out, valid, busy, ovf, err});
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int   n;
    bit   ok;
    res_t e, o;
    set_digits(1, 2, 3);
    exp_q.push_back(model(1, 2, 3));
    start = 1'b1;
    wait_busy(n);
    total++;
    if (!busy) $display("FAIL basic_busy_timeout got busy=%b want 1", busy);
    else begin passed++; kpress = n; end
    repeat (12) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    drain(ok);
    total++;
    if (!ok) $display("FAIL basic_timeout got %0d results want %0d",
                      obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL basic_result got %h want %h", o, e);
      else passed++;
    end
    exp_q.delete();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    total++;
    if ({valid, value_out} !== {1'b0, 8'd123})
      $display("FAIL basic_rd got valid=%b value=%0d want 0/123",
               valid, value_out);
    else passed++;
  endtask

  task automatic test_conversions();
    int tbl[8][3] = '{'{2,5,6}, '{2,5,5}, '{0,0,0}, '{9,9,9},
                      '{1,10,3}, '{15,15,15}, '{0,9,9}, '{1,0,0}};
    bit   ok;
    res_t e, o;
    foreach (tbl[i]) begin
      set_digits(tbl[i][0], tbl[i][1], tbl[i][2]);
      exp_q.push_back(model(tbl[i][0], tbl[i][1], tbl[i][2]));
      tap();
      drain(ok);
      total++;
      if (!ok) $display("FAIL conv%0d_timeout got %0d want %0d",
                        i, obs_q.size(), exp_q.size());
      else passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
        if (o !== e) $display("FAIL conv%0d got %h want %h", i, o, e);
        else passed++;
      end
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    bit   ok;
    res_t e, o;
    obs_q.delete();
    set_digits(0, 4, 2);
    for (int w = 1; w <= 3; w++) begin
      start = 1'b1;
      repeat (w) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
    end
    total++;
    if (obs_q.size() != 0 || busy !== 1'b0)
      $display("FAIL bounce_glitch got %0d results busy=%b want 0/0",
               obs_q.size(), busy);
    else passed++;
    exp_q.push_back(model(0, 4, 2));
    start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    drain(ok);
    total++;
    if (obs_q.size() != 1)
      $display("FAIL bounce_count got %0d want 1", obs_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL bounce_result got %h want %h", o, e);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_ignore_in_conv();
    int   n;
    bit   ok;
    res_t e, o;
    set_digits(1, 2, 3);
    exp_q.push_back(model(1, 2, 3));
    start = 1'b1;
    wait_busy(n);
    set_digits(9, 9, 9);
    rd = 1'b1;
    repeat (2) @(negedge clk);
    rd = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    drain(ok);
    total++;
    if (!ok) $display("FAIL ignore_timeout got %0d want %0d",
                      obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL ignore_result got %h want %h", o, e);
      else passed++;
    end
    exp_q.delete();
    total++;
    if (valid !== 1'b1)
      $display("FAIL ignore_valid_held got %b want 1", valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit   ok;
    res_t e, o;
    set_digits(2, 0, 7);
    exp_q.push_back(model(2, 0, 7));
    start = 1'b1;
    repeat (kpress - 1) @(negedge clk);
    total++;
    if ({valid, busy} !== 2'b10)
      $display("FAIL b2b_pre got valid/busy=%b want 10", {valid, busy});
    else passed++;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    total++;
    if ({valid, busy} !== 2'b01)
      $display("FAIL b2b_restart got valid/busy=%b want 01", {valid, busy});
    else passed++;
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    drain(ok);
    total++;
    if (!ok) $display("FAIL b2b_timeout got %0d want %0d",
                      obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL b2b_result got %h want %h", o, e);
      else passed++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midconv();
    int n;
    obs_q.delete();
    set_digits(1, 1, 1);
    start = 1'b1;
    wait_busy(n);
    @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({value_out, valid, busy, ovf, err} !== 12'd0)
      $display("FAIL midconv_reset got %h want 000",
               {value_out, valid, busy, ovf, err});
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || {valid, busy} !== 2'b00)
      $display("FAIL midconv_spurious got %0d results valid/busy=%b want 0/00",
               obs_q.size(), {valid, busy});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conversions();
    test_bounce();
    test_ignore_in_conv();
    test_back_to_back();
    test_reset_midconv();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
